// File: rtl/frame_scan_reader.sv
// Raster-order frame-buffer reader that streams pixels over valid/ready behind a credit-managed buffer.
// Optional FRAME_SCAN_LOOP_EN: rescan continuously, pulsing done on every end-of-frame handshake.
module frame_scan_reader #(
  parameter int Width     = 320,
  parameter int Height    = 240,
  parameter int ColorBits = 8,
  parameter int BufDepth  = 4,
  localparam int XW = $clog2(Width),
  localparam int YW = $clog2(Height)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [XW-1:0]        XRead,
  output logic [YW-1:0]        YRead,
  input  logic [ColorBits-1:0] RRead,
  input  logic [ColorBits-1:0] GRead,
  input  logic [ColorBits-1:0] BRead,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [ColorBits-1:0] pix_r,
  output logic [ColorBits-1:0] pix_g,
  output logic [ColorBits-1:0] pix_b,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 pix_sol,
  output logic                 pix_eol,
  output logic                 pix_eof
);

  localparam int PW = $clog2(BufDepth);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [ColorBits-1:0] r;
    logic [ColorBits-1:0] g;
    logic [ColorBits-1:0] b;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic                 sol;
    logic                 eol;
    logic                 eof;
  } pix_t;

  state_t          r_state, w_stateNext;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_inflight;
  logic [XW-1:0]   r_tagX;
  logic [YW-1:0]   r_tagY;
  logic            r_tagSol, r_tagEol, r_tagEof;
  pix_t            r_buf [BufDepth];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  pix_t            w_head;
  logic [CW-1:0]   w_used;
  logic            w_issue, w_push, w_pop, w_valid;
  logic            w_lastX, w_lastY, w_lastAddr;
  logic            w_startScan, w_drainDone;

  // A read is only issued when its returning word is guaranteed a buffer slot.
  assign w_used     = r_count + CW'(r_inflight);
  assign w_issue    = (r_state == SCAN) && (w_used < CW'(BufDepth));
  assign w_lastX    = (r_x == XW'(Width - 1));
  assign w_lastY    = (r_y == YW'(Height - 1));
  assign w_lastAddr = w_lastX && w_lastY;
  assign w_valid    = (r_count != '0);
  assign w_push     = r_inflight;
  assign w_pop      = w_valid && pix_ready;
  assign w_head     = r_buf[r_head];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_startScan = 1'b0;
    w_drainDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = SCAN;
          w_startScan = 1'b1;
        end
      end
      SCAN: begin
`ifndef FRAME_SCAN_LOOP_EN
        if (w_issue && w_lastAddr) w_stateNext = DRAIN;
`endif
      end
      DRAIN: begin
        if (!w_valid && !r_inflight) begin
          w_stateNext = IDLE;
          w_drainDone = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Wrap is by explicit compare so non-power-of-two frames count correctly.
  always_ff @(posedge clk) begin
    if (rst || w_startScan) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_issue) begin
      if (!w_lastX) begin
        r_x <= r_x + XW'(1);
      end else if (!w_lastY) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end
`ifdef FRAME_SCAN_LOOP_EN
      else begin
        r_x <= '0;
        r_y <= '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_tagX     <= '0;
      r_tagY     <= '0;
      r_tagSol   <= 1'b0;
      r_tagEol   <= 1'b0;
      r_tagEof   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tagX   <= r_x;
        r_tagY   <= r_y;
        r_tagSol <= (r_x == '0);
        r_tagEol <= w_lastX;
        r_tagEof <= w_lastAddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_tail] <= {RRead, GRead, BRead, r_tagX, r_tagY, r_tagSol, r_tagEol, r_tagEof};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FRAME_SCAN_LOOP_EN
  logic r_eofDone;

  always_ff @(posedge clk) begin
    if (rst) r_eofDone <= 1'b0;
    else     r_eofDone <= w_pop && w_head.eof;
  end

  assign done = r_eofDone;
`else
  assign done = w_drainDone;
`endif

  assign busy      = (r_state != IDLE) && !w_drainDone;
  assign XRead     = r_x;
  assign YRead     = r_y;
  assign pix_valid = w_valid;
  assign pix_r     = w_head.r;
  assign pix_g     = w_head.g;
  assign pix_b     = w_head.b;
  assign pix_x     = w_head.x;
  assign pix_y     = w_head.y;
  assign pix_sol   = w_head.sol;
  assign pix_eol   = w_head.eol;
  assign pix_eof   = w_head.eof;

endmodule

// File: tb/tb_frame_scan_reader.sv
// Bench for frame_scan_reader on a reduced 10x6 frame; pixels are scored against a raster-index model.
// Build with FRAME_SCAN_LOOP_EN defined to exercise continuous-scan mode.
module tb_frame_scan_reader;

  localparam int W  = 10;
  localparam int H  = 6;
  localparam int CB = 8;
  localparam int BD = 4;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CB-1:0] r;
    logic [CB-1:0] g;
    logic [CB-1:0] b;
    logic          sol;
    logic          eol;
    logic          eof;
  } pix_t;

  typedef struct {
    int stallCycles;
    int expX;
    int expValid;
  } stallVec_t;

  logic          clk = 1'b0;
  logic          rst, start, pix_ready;
  logic          busy, done, pix_valid;
  logic [XW-1:0] XRead, pix_x;
  logic [YW-1:0] YRead, pix_y;
  logic [CB-1:0] RRead, GRead, BRead, pix_r, pix_g, pix_b;
  logic          pix_sol, pix_eol, pix_eof;

  int checks = 0, errors = 0;
  int cyc = 0, startCyc = 0;
  int handshakes = 0, expIdx = 0, lastHs = 0, maxGap = 0;
  int doneCount = 0, firstDoneCyc = 0, lastDoneCyc = 0;
  bit monEn = 1'b0, prevStall = 1'b0;
  pix_t curPix, heldPix;
  logic [3:0] pat;
  stallVec_t vecs [7];

  frame_scan_reader #(.Width(W), .Height(H), .ColorBits(CB), .BufDepth(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .XRead(XRead), .YRead(YRead), .RRead(RRead), .GRead(GRead), .BRead(BRead),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: data for an address appears one cycle later.
  always @(posedge clk) begin
    RRead <= CB'(XRead);
    GRead <= CB'(YRead);
    BRead <= CB'(XRead) ^ CB'(YRead);
  end

  function automatic pix_t modelPixel(int k);
    pix_t m;
    int px, py;
    px = k % W;
    py = (k / W) % H;
    m.x = XW'(px);
    m.y = YW'(py);
    m.r = CB'(px);
    m.g = CB'(py);
    m.b = CB'(px ^ py);
    m.sol = (px == 0);
    m.eol = (px == W - 1);
    m.eof = (px == W - 1) && (py == H - 1);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: raster order, stall stability, credit bound and done bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      expIdx = 0;
      prevStall = 1'b0;
    end else if (monEn) begin
      int used;
      curPix = {pix_x, pix_y, pix_r, pix_g, pix_b, pix_sol, pix_eol, pix_eof};
      used = int'(dut.r_count) + int'(dut.r_inflight);
      checkOutput("credit", 64'(used <= BD), 64'(1));
      if (prevStall) begin
        checkOutput("stallValid", 64'(pix_valid), 64'(1));
        checkOutput("stallHold", 64'(curPix), 64'(heldPix));
      end
      if (pix_valid && pix_ready) begin
        checkOutput("pixel", 64'(curPix), 64'(modelPixel(expIdx)));
        if (handshakes > 0 && cyc - lastHs > maxGap) maxGap = cyc - lastHs;
        lastHs = cyc;
        handshakes++;
        expIdx++;
      end
      prevStall = pix_valid && !pix_ready;
      heldPix = curPix;
      if (done) begin
        doneCount++;
        if (doneCount == 1) firstDoneCyc = cyc;
        lastDoneCyc = cyc;
`ifndef FRAME_SCAN_LOOP_EN
        checkOutput("busyAtDone", 64'(busy), 64'(0));
`endif
      end
    end
  end

  task automatic doReset;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulseStart;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    startCyc = cyc;
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic applyStimulus(input int mode, input bit dupStart, input int budget);
    handshakes = 0;
    doneCount = 0;
    maxGap = 0;
    pix_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    pulseStart;
    for (int k = 1; k <= budget && doneCount == 0; k++) begin
      if (mode == 0)      pix_ready = 1'b1;
      else if (mode == 1) pix_ready = pat[k % 4];
      else                pix_ready = 1'($urandom_range(0, 1));
      start = dupStart && (k == 10 || k == 40);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("doneSeen", 64'(doneCount), 64'(1));
    checkOutput("frameCount", 64'(handshakes), 64'(W * H));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    pat = 4'b1001;
    vecs[0] = '{0, 0, 0};
    vecs[1] = '{1, 1, 0};
    vecs[2] = '{2, 2, 1};
    vecs[3] = '{3, 3, 1};
    vecs[4] = '{4, 4, 1};
    vecs[5] = '{5, 4, 1};
    vecs[6] = '{20, 4, 1};

    repeat (2) @(posedge clk); #1;
    checkOutput("rstBusy", 64'(busy), 64'(0));
    checkOutput("rstDone", 64'(done), 64'(0));
    checkOutput("rstValid", 64'(pix_valid), 64'(0));
    checkOutput("rstX", 64'(XRead), 64'(0));
    checkOutput("rstY", 64'(YRead), 64'(0));
    rst = 1'b0;

    // Downstream stalled from start: reads stop once the buffer is fully credited.
    for (int i = 0; i < 7; i++) begin
      doReset;
      pix_ready = 1'b0;
      pulseStart;
      repeat (vecs[i].stallCycles) @(posedge clk);
      #1;
      checkOutput($sformatf("stallX[%0d]", vecs[i].stallCycles), 64'(XRead), 64'(vecs[i].expX));
      checkOutput($sformatf("stallY[%0d]", vecs[i].stallCycles), 64'(YRead), 64'(0));
      checkOutput($sformatf("stallV[%0d]", vecs[i].stallCycles), 64'(pix_valid), 64'(vecs[i].expValid));
      checkOutput($sformatf("stallBusy[%0d]", vecs[i].stallCycles), 64'(busy), 64'(1));
    end

    monEn = 1'b1;
`ifndef FRAME_SCAN_LOOP_EN
    doReset;
    applyStimulus(0, 1'b0, W * H * 4);
    checkOutput("doneLatency", 64'(firstDoneCyc - startCyc), 64'(W * H + 2));
    checkOutput("noBubble", 64'(maxGap), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("singleDone", 64'(doneCount), 64'(1));
    checkOutput("idleBusy", 64'(busy), 64'(0));
    checkOutput("holdX", 64'(XRead), 64'(W - 1));
    checkOutput("holdY", 64'(YRead), 64'(H - 1));

    doReset;
    applyStimulus(1, 1'b0, W * H * 8);
    for (int f = 0; f < 2; f++) begin
      doReset;
      applyStimulus(2, 1'b0, W * H * 16);
    end

    doReset;
    applyStimulus(0, 1'b1, W * H * 4);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("dupStartDone", 64'(doneCount), 64'(1));
    checkOutput("dupStartBusy", 64'(busy), 64'(0));

    // Abandon a frame mid-stream, then confirm a clean restart from (0,0).
    doReset;
    handshakes = 0;
    doneCount = 0;
    pix_ready = 1'b1;
    pulseStart;
    for (int k = 0; k < 200 && handshakes < 20; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("reachPix20", 64'(handshakes >= 20), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRstValid", 64'(pix_valid), 64'(0));
    checkOutput("midRstBusy", 64'(busy), 64'(0));
    checkOutput("midRstDone", 64'(done), 64'(0));
    rst = 1'b0;
    repeat (W * H) @(posedge clk);
    #1;
    checkOutput("midRstNoDone", 64'(doneCount), 64'(0));
    applyStimulus(0, 1'b0, W * H * 4);
`else
    doReset;
    handshakes = 0;
    doneCount = 0;
    maxGap = 0;
    pix_ready = 1'b1;
    pulseStart;
    for (int k = 0; k < W * H * 4 && doneCount < 2; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("loopDoneCount", 64'(doneCount), 64'(2));
    checkOutput("loopFirstDone", 64'(firstDoneCyc - startCyc), 64'(W * H + 2));
    checkOutput("loopDonePeriod", 64'(lastDoneCyc - firstDoneCyc), 64'(W * H));
    checkOutput("loopNoBubble", 64'(maxGap), 64'(1));
    checkOutput("loopSecondFrame", 64'(handshakes > W * H), 64'(1));
    checkOutput("loopBusy", 64'(busy), 64'(1));
    doReset;
`endif
    monEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scan_reader.md
Name: frame_scan_reader

Overview:
- Downstream consumer of the frame-buffer memory.
- On `start`, drives the memory read port (X/Y) in raster order, top-left (0,0) to bottom-right (Width-1, Height-1).
- Captures the returned RGB and streams it to the next stage (display/serializer) over a valid/ready pixel interface.
- Absorbs the memory's read latency and downstream backpressure with an internal credit-managed output buffer.

Parameters:
- Width, 320, frame width in pixels; XW = $clog2(Width) = 9.
- Height, 240, frame height in lines; YW = $clog2(Height) = 8.
- ColorBits, 8, bits per colour channel.
- BufDepth, 4, output buffer entries; must be a power of two ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame scan when idle.
- busy  out  1  high from accepted start until the last pixel is handed off.
- done  out  1  one-cycle pulse when the last pixel (eof) is accepted downstream.
- XRead  out  XW  memory read column address.
- YRead  out  YW  memory read row address.
- RRead, GRead, BRead  in  ColorBits each  memory read data; valid 1 cycle after the address.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts when valid&&ready.
- pix_r, pix_g, pix_b  out  ColorBits each  pixel colour.
- pix_x  out  XW  pixel column.
- pix_y  out  YW  pixel row.
- pix_sol  out  1  first pixel of a line (x==0).
- pix_eol  out  1  last pixel of a line (x==Width-1).
- pix_eof  out  1  last pixel of the frame.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - Outputs: busy=0, done=0, pix_valid=0, XRead=0, YRead=0.
  - Internal state: buffer emptied, in-flight pipe cleared, FSM=IDLE.
  - Reset mid-frame abandons the frame with no done pulse.
- Memory timing: address driven in cycle N returns data in cycle N+1. A 1-bit issue pipe tags each returning word with its x/y/sol/eol/eof.
- FSM:
  - IDLE: wait for start. On start: busy=1, address counters set to (0,0), go to SCAN. start while not IDLE is ignored.
  - SCAN: issue a read in a cycle iff occupancy + inflight < BufDepth.
    - On issue, X increments. At X=Width-1, X wraps to 0 and Y increments.
    - After issuing (Width-1, Height-1), go to DRAIN. XRead/YRead hold the last address.
  - DRAIN: wait until buffer empty and no read in flight, then go to IDLE with done=1 for one cycle and busy=0 in the same cycle.
- Returned data is written into the buffer tail in the cycle it arrives. The credit rule guarantees no overflow. Write while full is a design error; verification asserts it never occurs.
- Output side: pix_* reflect the buffer head. pix_valid = !empty.
  - Head pops on pix_valid && pix_ready.
  - pix_* remain stable while pix_valid && !pix_ready.
  - Simultaneous push and pop in one cycle keeps occupancy unchanged.
- Throughput: with pix_ready held high, one pixel per cycle.
  - First pix_valid 2 cycles after the start cycle: issue in cycle 1, data returns in cycle 2.
  - Frame completes in Width*Height + 2 cycles after start; done asserts in the cycle after the eof handshake.
- Tags: pix_sol/pix_eol/pix_eof are registered alongside data, never combinational from counters.
- Counters: X counts 0..Width-1 and Y counts 0..Height-1. Non-power-of-two wrap is by explicit compare, not overflow.

Optional Feature:
- Macro: FRAME_SCAN_LOOP_EN.
- Defined:
  - After the last address issues, SCAN restarts at (0,0) in the next eligible cycle without waiting for start.
  - done still pulses once per frame on each eof handshake.
  - busy stays high until rst.
  - The pixel stream is seamless: no bubble at frame boundaries with pix_ready high.
- Undefined: single-shot behaviour as above; IDLE after DRAIN.

Test Plan:
- Reset then start, pix_ready=1, memory model returns R=x[7:0], G=y, B=x^y:
  - Exactly 76800 handshakes in raster order.
  - First pixel (0,0) sol=1.
  - Pixel 319 eol=1.
  - Pixel 76799 (319,239) eof=1.
  - done exactly one cycle after, at cycle 76802 after start.
- Backpressure:
  - pix_ready toggles 1,0,0,1 repeating: no pixel lost or duplicated; pix_* stable while stalled.
  - Occupancy+inflight never exceeds 4.
  - pix_ready=0 for 20 cycles after start: exactly 4 reads issued, then XRead/YRead frozen at X=4.
- start pulsed at cycles 10 and 500 of a frame: second pulse ignored, single done.
- rst asserted at pixel 1000 with pix_ready=1:
  - Next cycle pix_valid=0, busy=0, no done.
  - New start yields first pixel (0,0).
- FRAME_SCAN_LOOP_EN defined, pix_ready=1:
  - Two frames back-to-back with no bubble.
  - Pixel 76800 is (0,0) sol=1; done pulses twice, 76800 cycles apart.
